// File: rtl/waveform_sequencer.sv
// Steps a waveform generator through the selections enabled in a mask, priming it
// with a one-cycle reset before each selection and holding it for a programmable dwell.
module waveform_sequencer #(
  parameter int DWELL_W       = 16,
  parameter int DEFAULT_DWELL = 2048
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic [7:0]         enable_mask,
  input  logic               dwell_load,
  input  logic [DWELL_W-1:0] dwell_value,
  output logic [2:0]         sel,
  output logic               wave_rst,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, PRIME, DWELL} state_t;

  state_t             state, state_nxt;
  logic [2:0]         sel_nxt;
  logic               done_nxt;
  logic               accept;
  logic [3:0]         hit;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [DWELL_W-1:0] dwell_reg;
  logic [7:0]         mask_q;
  logic               loop_q;

  // {found, index} of the lowest set mask bit strictly above cur
  function automatic logic [3:0] first_above(input logic [7:0] m, input logic [2:0] cur);
    first_above = 4'b0;
    for (int i = 7; i >= 0; i--)
      if (m[i] && (i > int'(cur))) first_above = {1'b1, 3'(i)};
  endfunction

  function automatic logic [2:0] first_set(input logic [7:0] m);
    first_set = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) first_set = 3'(i);
  endfunction

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    hit       = 4'b0;
    accept    = (state == IDLE) && start && !stop && (enable_mask != 8'h00);
    case (state)
      IDLE: begin
        if (accept) begin
          sel_nxt   = first_set(enable_mask);
          state_nxt = PRIME;
        end
      end
      PRIME: begin
        cnt_nxt   = dwell_reg - DWELL_W'(1);
        state_nxt = DWELL;
      end
      DWELL: begin
        if (cnt == '0) begin
          hit = first_above(mask_q, sel);
          if (hit[3]) begin
            sel_nxt   = hit[2:0];
            state_nxt = PRIME;
          end else if (loop_q) begin
            sel_nxt   = first_set(mask_q);
            state_nxt = PRIME;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - DWELL_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // An abort wins over any advance or completion, leaving sel where it was
    if (stop && (state != IDLE)) begin
      state_nxt = IDLE;
      sel_nxt   = sel;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 3'd0;
      wave_rst  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      mask_q    <= 8'h00;
      loop_q    <= 1'b0;
      dwell_reg <= DWELL_W'(DEFAULT_DWELL);
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      cnt      <= cnt_nxt;
      wave_rst <= (state_nxt == PRIME);
      busy     <= (state_nxt != IDLE);
      done     <= done_nxt;
      if (accept) begin
        mask_q <= enable_mask;
        loop_q <= loop;
      end
      // Zero would make the dwell counter wrap, so it is stored as the minimum of 1
      if ((state == IDLE) && dwell_load)
        dwell_reg <= (dwell_value == '0) ? DWELL_W'(1) : dwell_value;
    end
  end

endmodule

// File: doc/waveform_sequencer.md
WAVEFORM_SEQUENCER -- requirements
Module: waveform_sequencer

Interface
REQ-001 Parameter DWELL_W, default 16, SHALL set the dwell counter and dwell register width.
REQ-002 Parameter DEFAULT_DWELL, default 2048, SHALL set the dwell register value after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 start  input  1  SHALL request a sweep; level sampled each edge.
REQ-006 stop  input  1  SHALL abort a running sweep.
REQ-007 loop  input  1  SHALL select repeat-forever (1) or single sweep (0); captured on accepted start.
REQ-008 enable_mask  input  8  SHALL mark which sel codes 0..7 are visited; captured on accepted start.
REQ-009 dwell_load  input  1  SHALL request loading dwell_value into the dwell register.
REQ-010 dwell_value  input  DWELL_W  SHALL be the per-selection dwell in clk cycles.
REQ-011 sel  output  3  SHALL drive the waveform generator's selection input; registered.
REQ-012 wave_rst  output  1  SHALL drive the waveform generator's reset; registered; high exactly during PRIME.
REQ-013 busy  output  1  SHALL be high in every non-IDLE state; registered.
REQ-014 done  output  1  SHALL pulse for one cycle when a single sweep completes; registered.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, PRIME, DWELL.
REQ-016 Start acceptance: IDLE, start=1, stop=0, enable_mask!=0 -> capture mask and loop; sel <= lowest set mask index; next state PRIME.
REQ-017 start with enable_mask==0, start while busy, or start with stop=1 in the same cycle SHALL be ignored.
REQ-018 PRIME SHALL last one cycle: wave_rst=1; dwell counter <= dwell register - 1; next state DWELL.
REQ-019 DWELL SHALL last exactly dwell-register cycles: counter decrements each cycle; wave_rst=0; sel held.
REQ-020 On the final DWELL cycle (counter==0), with a captured-mask bit set above the current sel: sel <= lowest such index; next state PRIME.
REQ-021 On the final DWELL cycle with no higher set bit and loop=1: sel <= lowest set index (wrap-around); next state PRIME.
REQ-022 On the final DWELL cycle with no higher set bit and loop=0: next state IDLE; done=1 for the first IDLE cycle only; sel held.
REQ-023 Each visited selection SHALL therefore be presented for dwell+1 cycles: 1 PRIME and dwell DWELL cycles.
REQ-024 A single-selection mask with loop=1 SHALL re-enter PRIME on the same sel every dwell+1 cycles.
REQ-025 stop=1 in PRIME or DWELL SHALL force IDLE on the next edge: busy=0, wave_rst=0, done=0, sel held; takes priority over every completion/advance transition.
REQ-026 dwell_load SHALL update the dwell register only in IDLE; ignored while busy, so a running sweep uses a constant dwell.
REQ-027 dwell_value==0 SHALL be stored as 1.
REQ-028 dwell_load and an accepted start in the same IDLE cycle: new value stored and used by that sweep.
REQ-029 The captured mask and loop SHALL NOT change during a sweep, regardless of input changes.

Reset
REQ-030 rst=1 SHALL, on the next edge, force IDLE, sel=0, wave_rst=0, busy=0, done=0, dwell counter=0, captured mask=0, loop=0, dwell register=DEFAULT_DWELL.
REQ-031 rst SHALL override start, stop and dwell_load, including mid-sweep; no done pulse is produced.

Verification
REQ-032 dwell_load 4 in IDLE, then start (edge 0), mask 8'b0000_0101, loop=0 -> cycle 1 PRIME sel=0 wave_rst=1; cycles 2-5 sel=0; cycle 6 PRIME sel=2; cycles 7-10 sel=2; cycle 11 done=1 busy=0 sel=2; cycle 12 done=0.
REQ-033 After reset, start, mask 8'hFF, loop=0 -> sel 0..7 in order, each 2049 cycles, wave_rst one cycle per change, done at cycle 16393.
REQ-034 dwell 2, mask 8'b1000_0010, loop=1 -> sel 1,7,1,7,... every 3 cycles, done never asserted; stop -> busy=0 next cycle, sel held.
REQ-035 stop asserted on the final DWELL cycle of the last selection, loop=0 -> IDLE, done stays 0.
REQ-036 start with mask 0, start while busy, dwell_load 9 while busy -> all ignored; running dwell unchanged; 9 not stored.
REQ-037 rst mid-DWELL with dwell 7 loaded -> next cycle all outputs at reset values; a new sweep dwells 2048 cycles; dwell_value 0 loaded -> each selection lasts 2 cycles.
